// File: rtl/mem_wb_pipeline_register.sv
// ============================================================================
// Module   : mem_wb_pipeline_register
// Brief    : MEM/WB pipeline stage register with cache-miss stall and sync clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_pipeline_register #(
   parameter int DATA_WIDTH      = 32,
   parameter int REG_INDEX_WIDTH = 5
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       hit,
   input  logic                       RegWrite,
   input  logic                       MemToReg,
   input  logic [DATA_WIDTH-1:0]      data_memory_read_data,
   input  logic [DATA_WIDTH-1:0]      ALU_result,
   input  logic [REG_INDEX_WIDTH-1:0] write_register_index,
   output logic                       RegWrite_output,
   output logic                       MemtoReg_output,
   output logic [DATA_WIDTH-1:0]      data_memory_read_data_output,
   output logic [DATA_WIDTH-1:0]      ALU_result_output,
   output logic [REG_INDEX_WIDTH-1:0] write_register_index_output
);

   // All fields share one enable so the stage always moves as a single unit;
   // a miss (hit=0) freezes the whole stage, clear wins over the stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         RegWrite_output              <= 1'b0;
         MemtoReg_output              <= 1'b0;
         data_memory_read_data_output <= '0;
         ALU_result_output            <= '0;
         write_register_index_output  <= '0;
      end else if (hit) begin
         RegWrite_output              <= RegWrite;
         MemtoReg_output              <= MemToReg;
         data_memory_read_data_output <= data_memory_read_data;
         ALU_result_output            <= ALU_result;
         write_register_index_output  <= write_register_index;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipeline_register.sv
// ============================================================================
// Module   : tb_mem_wb_pipeline_register
// Brief    : Directed self-checking bench with per-cycle stage model compare
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_pipeline_register;

   localparam int DW = 32;
   localparam int IW = 5;

   typedef struct packed {
      logic          rw;
      logic          m2r;
      logic [DW-1:0] data;
      logic [DW-1:0] alu;
      logic [IW-1:0] idx;
   } stage_t;

   logic          clock = 1'b0;
   logic          reset, hit, rw_in, m2r_in;
   logic [DW-1:0] data_in, alu_in;
   logic [IW-1:0] idx_in;
   logic          rw_out, m2r_out;
   logic [DW-1:0] data_out, alu_out;
   logic [IW-1:0] idx_out;

   int checks = 0;
   int fails  = 0;

   stage_t model;
   bit     model_valid = 1'b0;

   mem_wb_pipeline_register #(.DATA_WIDTH(DW), .REG_INDEX_WIDTH(IW)) dut (
      .clock                        (clock),
      .reset                        (reset),
      .hit                          (hit),
      .RegWrite                     (rw_in),
      .MemToReg                     (m2r_in),
      .data_memory_read_data        (data_in),
      .ALU_result                   (alu_in),
      .write_register_index         (idx_in),
      .RegWrite_output              (rw_out),
      .MemtoReg_output              (m2r_out),
      .data_memory_read_data_output (data_out),
      .ALU_result_output            (alu_out),
      .write_register_index_output  (idx_out)
   );

   always #5 clock = ~clock;

   // Model: a stage register is "what was presented at the last enabled edge".
   always @(posedge clock) begin
      if (reset) begin
         model       = '0;
         model_valid = 1'b1;
      end else if (hit) begin
         model = '{rw: rw_in, m2r: m2r_in, data: data_in, alu: alu_in, idx: idx_in};
      end
   end

   stage_t dut_now;
   assign dut_now = '{rw: rw_out, m2r: m2r_out, data: data_out, alu: alu_out, idx: idx_out};

   always @(negedge clock) begin
      if (model_valid) begin
         checks++;
         if (dut_now !== model) begin
            fails++;
            $display("FAIL model_cmp t=%0t got rw=%b m2r=%b data=%h alu=%h idx=%0d want rw=%b m2r=%b data=%h alu=%h idx=%0d",
                     $time, rw_out, m2r_out, data_out, alu_out, idx_out,
                     model.rw, model.m2r, model.data, model.alu, model.idx);
         end
      end
   end

   task automatic check(input string name, input stage_t want);
      checks++;
      if (dut_now !== want) begin
         fails++;
         $display("FAIL %s got rw=%b m2r=%b data=%h alu=%h idx=%0d want rw=%b m2r=%b data=%h alu=%h idx=%0d",
                  name, rw_out, m2r_out, data_out, alu_out, idx_out,
                  want.rw, want.m2r, want.data, want.alu, want.idx);
      end
   endtask

   task automatic edge_step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic [DW-1:0] d,
                        input logic [DW-1:0] a, input logic [IW-1:0] i);
      rw_in = rw; m2r_in = m2r; data_in = d; alu_in = a; idx_in = i;
   endtask

   stage_t zero_s, first_s, second_s, held_s;

   initial begin
      zero_s   = '0;
      first_s  = '{rw: 1'b1, m2r: 1'b1, data: 32'd111, alu: 32'd222, idx: 5'd31};
      second_s = '{rw: 1'b0, m2r: 1'b0, data: 32'hDEADBEEF, alu: 32'h12345678, idx: 5'd7};

      // Reset held for two edges with busy inputs
      reset = 1'b1; hit = 1'b1;
      drive(1'b1, 1'b1, 32'd111, 32'd222, 5'd31);
      edge_step();
      edge_step();
      check("reset_clear", zero_s);

      // Capture: not visible before the edge, visible after it
      reset = 1'b0; hit = 1'b1;
      #2 check("capture_before_edge", zero_s);
      edge_step();
      check("capture_after_edge", first_s);

      // Stall for three edges with changed inputs, then resume
      hit = 1'b0;
      drive(1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd7);
      for (int k = 0; k < 3; k++) begin
         edge_step();
         check("stall_hold", first_s);
      end
      hit = 1'b1;
      edge_step();
      check("stall_resume", second_s);

      // Truncation of an out-of-range index, all-ones data
      drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, IW'(32));
      edge_step();
      check("truncate_idx", '{rw: 1'b1, m2r: 1'b0, data: 32'hFFFFFFFF, alu: 32'h0, idx: 5'd0});

      // Reset beats stall
      drive(1'b1, 1'b1, 32'h0000A5A5, 32'h00005A5A, 5'd19);
      edge_step();
      held_s = '{rw: 1'b1, m2r: 1'b1, data: 32'h0000A5A5, alu: 32'h00005A5A, idx: 5'd19};
      check("load_before_prio", held_s);
      hit = 1'b0; reset = 1'b1;
      edge_step();
      check("reset_over_stall", zero_s);

      // Reset pulse between edges has no effect
      reset = 1'b0; hit = 1'b1;
      edge_step();
      check("reload", held_s);
      hit = 1'b0;
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      #1 check("reset_glitch_between_edges", held_s);
      edge_step();
      check("reset_glitch_after_edge", held_s);

      // Back-to-back capture, one edge latency each
      hit = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b1, 32'(k * 16), 32'(k), 5'(k));
         edge_step();
         check("back_to_back", '{rw: 1'b0, m2r: 1'b1, data: 32'(k * 16), alu: 32'(k), idx: 5'(k)});
      end

      // Input wiggle mid-cycle must not leak to outputs
      hit = 1'b0;
      #2 drive(1'b1, 1'b0, 32'h1, 32'h2, 5'd3);
      #2 check("mid_cycle_inputs", '{rw: 1'b0, m2r: 1'b1, data: 32'd64, alu: 32'd4, idx: 5'd4});
      edge_step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_wb_pipeline_register.md
MEM_WB_PIPELINE_REGISTER -- requirements
Module: mem_wb_pipeline_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data memory read data and ALU result paths.
REQ-002 SHALL have parameter REG_INDEX_WIDTH, default 5, width of the register file write index.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high clear of all stored state.
REQ-006 hit  input  1  data-cache hit / advance enable; 1 = capture inputs, 0 = stall (hold).
REQ-007 RegWrite  input  1  WB-stage register-file write enable from MEM stage.
REQ-008 MemToReg  input  1  WB-stage mux select from MEM stage; 1 = memory data, 0 = ALU result.
REQ-009 data_memory_read_data  input  DATA_WIDTH  load data read in MEM stage.
REQ-010 ALU_result  input  DATA_WIDTH  ALU result forwarded through MEM stage.
REQ-011 write_register_index  input  REG_INDEX_WIDTH  destination register number.
REQ-012 RegWrite_output  output  1  registered RegWrite.
REQ-013 MemtoReg_output  output  1  registered MemToReg.
REQ-014 data_memory_read_data_output  output  DATA_WIDTH  registered data_memory_read_data.
REQ-015 ALU_result_output  output  DATA_WIDTH  registered ALU_result.
REQ-016 write_register_index_output  output  REG_INDEX_WIDTH  registered write_register_index.

Function
REQ-017 All five outputs SHALL be driven directly from flip-flops; no combinational path from any input to any output.
REQ-018 On a rising clock edge with reset=0 and hit=1, every output SHALL take the value its corresponding input had before that edge; latency is exactly one cycle.
REQ-019 On a rising clock edge with reset=0 and hit=0, every output SHALL hold its previous value; pipeline stalls during a cache miss.
REQ-020 A stall SHALL be indefinite: outputs stay constant for any number of consecutive hit=0 cycles and resume capture on the first edge with hit=1.
REQ-021 Fields SHALL be captured as one unit: no edge may update some outputs and not others.
REQ-022 Data fields SHALL pass bit-exact with no sign extension, masking or arithmetic; values wider than the port are truncated to the port width by the driver, e.g. write_register_index driven with 32 stores 0.
REQ-023 Control fields SHALL be captured and held exactly like data fields; no gating of RegWrite by hit or any other input.
REQ-024 Between clock edges, input changes SHALL have no effect on outputs.
REQ-025 Before the first reset, output values are unspecified; the block SHALL NOT rely on initial values.

Reset
REQ-026 On a rising clock edge with reset=1, all outputs SHALL become 0: RegWrite_output=0, MemtoReg_output=0, data_memory_read_data_output=0, ALU_result_output=0, write_register_index_output=0.
REQ-027 reset SHALL take priority over hit; reset=1 with hit=0 still clears.
REQ-028 reset asserted mid-stream SHALL discard the in-flight stage contents; the first capture after reset is the input sampled on the first edge with reset=0 and hit=1.
REQ-029 reset SHALL have no asynchronous effect; asserting it between edges changes nothing until the next rising edge.

Verification
REQ-030 Reset: reset=1 for 2 edges with inputs RegWrite=1, MemToReg=1, data=111, ALU=222, idx=31 -> all outputs 0.
REQ-031 Capture: reset=0, hit=1, RegWrite=1, MemToReg=1, data=111, ALU=222, idx=31, one edge -> outputs 1,1,111,222,31 after that edge, not before.
REQ-032 Stall: after REQ-031, hit=0, inputs changed to 0,0,0xDEADBEEF,0x12345678,7 for 3 edges -> outputs remain 1,1,111,222,31; set hit=1 -> next edge shows 0,0,0xDEADBEEF,0x12345678,7.
REQ-033 Truncation: idx driven with 32 and hit=1 -> write_register_index_output=0; data=0xFFFFFFFF passes unchanged.
REQ-034 Priority: reset=1 with hit=0 while outputs hold nonzero values -> all outputs 0 on that edge; reset pulsed between edges -> no change.
REQ-035 Back-to-back: hit=1, ALU_result=1,2,3,4 on consecutive edges -> ALU_result_output shows 1,2,3,4, each one edge later.
